// File: rtl/tart_bank_switch_if.sv
// Signal bundle between the acquisition front end (master) and the bank sequencer (slave).
// strobe_i and free_i are single-cycle pulses with no back-pressure: each high cycle is one event, consumed on that clock edge.
interface tart_bank_switch_if #(
  parameter int BLOCK = 24,
  parameter int XBITS = 2
);
  logic             enable_i;
  logic [BLOCK-1:0] block_i;
  logic             strobe_i;
  logic             free_i;
  logic             en_o;
  logic             sw_o;
  logic             newblock_o;
  logic [XBITS-1:0] wr_bank_o;
  logic [XBITS-1:0] rd_bank_o;
  logic [XBITS-1:0] pending_o;
  logic             ready_o;
  logic             overflow_o;
  logic             busy_o;
  logic [1:0]       state_o;

  modport master (
    output enable_i, block_i, strobe_i, free_i,
    input  en_o, sw_o, newblock_o, wr_bank_o, rd_bank_o, pending_o,
           ready_o, overflow_o, busy_o, state_o
  );

  modport slave (
    input  enable_i, block_i, strobe_i, free_i,
    output en_o, sw_o, newblock_o, wr_bank_o, rd_bank_o, pending_o,
           ready_o, overflow_o, busy_o, state_o
  );
endinterface

// File: rtl/tart_bank_switch.sv
// Block/bank sequencer for the correlator: counts sample strobes per block, pulses en/sw,
// and tracks written vs. unread visibility banks with sticky overflow.
module tart_bank_switch #(
  parameter int BLOCK = 24,
  parameter int XBITS = 2
) (
  input logic               clk_x,
  input logic               rst_i,
  tart_bank_switch_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [XBITS-1:0] PEND_MAX = '1;

  state_t           state_q, state_d;
  logic [BLOCK-1:0] cnt_q, size_q;
  logic [XBITS-1:0] wr_q, rd_q, pend_q;
  logic [XBITS-1:0] wr_d, rd_d, pend_d;
  logic             en_q, sw_q, ready_q, ovf_q;
  logic             take, last, free_ok, ovf_set;

  assign take    = (state_q != IDLE) && bus.strobe_i;
  assign last    = take && (cnt_q == size_q);
  assign free_ok = bus.free_i && (pend_q != '0);

  always_ff @(posedge clk_x) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Dropping enable mid-block finishes the block in DRAIN; if the block ends on that very cycle there is nothing left to drain.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.enable_i) state_d = RUN;
      RUN:     if (!bus.enable_i) state_d = last ? IDLE : DRAIN;
      DRAIN:   if (last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A block end without a matching free either adds a pending bank or, when full, overwrites the oldest one.
  always_comb begin
    pend_d  = pend_q;
    ovf_set = 1'b0;
    if (last) begin
      if (!free_ok) begin
        if (pend_q == PEND_MAX) ovf_set = 1'b1;
        else                    pend_d  = pend_q + 1'b1;
      end
    end else if (free_ok) begin
      pend_d = pend_q - 1'b1;
    end
    wr_d = last ? wr_q + 1'b1 : wr_q;
    rd_d = wr_d - pend_d;
  end

  always_ff @(posedge clk_x) begin
    if (rst_i) begin
      cnt_q   <= '0;
      size_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      pend_q  <= '0;
      en_q    <= 1'b0;
      sw_q    <= 1'b0;
      ready_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      en_q    <= take;
      sw_q    <= last;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      pend_q  <= pend_d;
      ready_q <= (pend_d != '0);
      ovf_q   <= ovf_q | ovf_set;
      if (state_q == IDLE && bus.enable_i) begin
        cnt_q  <= '0;
        size_q <= bus.block_i;
      end else if (take) begin
        if (last) begin
          cnt_q  <= '0;
          size_q <= bus.block_i;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign bus.en_o       = en_q;
  assign bus.sw_o       = sw_q;
  assign bus.newblock_o = sw_q;
  assign bus.wr_bank_o  = wr_q;
  assign bus.rd_bank_o  = rd_q;
  assign bus.pending_o  = pend_q;
  assign bus.ready_o    = ready_q;
  assign bus.overflow_o = ovf_q;
  assign bus.busy_o     = (state_q != IDLE);
  assign bus.state_o    = state_q;

endmodule
